// File: rtl/sn74ls166_shift.sv
// 74LS166 8-bit parallel-in/serial-out shift register, pin-level model.
// Clock inhibit ORs into the dot clock; CLR_n clears asynchronously.
module sn74ls166_shift (
  input  logic p7,
  input  logic p9,
  input  logic p6,
  input  logic p15,
  input  logic p1,
  input  logic p2,
  input  logic p3,
  input  logic p4,
  input  logic p5,
  input  logic p10,
  input  logic p11,
  input  logic p12,
  input  logic p14,
  output logic p13
);

  logic       eclk;
  logic [7:0] d;
  logic [7:0] q = 8'h00;

  // Inhibit high holds eclk high, so p7 edges cannot reach the register.
  assign eclk = p7 | p6;
  assign d    = {p14, p12, p11, p10, p5, p4, p3, p2};

  always_ff @(posedge eclk or negedge p9) begin
    if (!p9) begin
      q <= 8'h00;
    end else if (!p15) begin
      q <= d;
    end else begin
      q <= {q[6:0], p1};
    end
  end

  assign p13 = q[7];

endmodule

// File: tb/tb_sn74ls166_shift.sv
// Directed bench for sn74ls166_shift.
// Expected QH values are hand-derived from the load/shift order.
module tb_sn74ls166_shift;

  logic p7, p9, p6, p15, p1;
  logic p2, p3, p4, p5, p10, p11, p12, p14;
  logic p13;

  int checks   = 0;
  int failures = 0;

  logic [15:0] pat;
  logic [7:0]  a5;

  sn74ls166_shift dut (
    .p7 (p7),
    .p9 (p9),
    .p6 (p6),
    .p15(p15),
    .p1 (p1),
    .p2 (p2),
    .p3 (p3),
    .p4 (p4),
    .p5 (p5),
    .p10(p10),
    .p11(p11),
    .p12(p12),
    .p14(p14),
    .p13(p13)
  );

  task automatic setd(input logic [7:0] v);
    {p14, p12, p11, p10, p5, p4, p3, p2} = v;
  endtask

  task automatic pulse();
    p7 = 1'b1;
    #5;
    p7 = 1'b0;
    #5;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    p7 = 0; p9 = 1; p6 = 0; p15 = 1; p1 = 0;
    setd(8'h00);
    #1;
    check("power_up", p13, 1'b0);

    // clear pulse with no clock edge
    #4;
    p15 = 0; setd(8'hFF);
    pulse();
    check("load_ff", p13, 1'b1);
    p9 = 0;
    #2;
    check("async_clr", p13, 1'b0);
    p9 = 1;
    #2;
    check("clr_release", p13, 1'b0);
    p15 = 1; p1 = 0;
    for (int i = 0; i < 3; i++) begin
      pulse();
      check("post_clr_shift", p13, 1'b0);
    end

    // load A5 then shift out with SER=0
    a5 = 8'hA5;
    p15 = 0; setd(a5);
    pulse();
    check("a5_e0", p13, 1'b1);
    p15 = 1; p1 = 0;
    setd(8'h00);
    for (int i = 1; i <= 8; i++) begin
      pulse();
      check($sformatf("a5_e%0d", i), p13, (i == 8) ? 1'b0 : a5[7-i]);
    end

    // serial fill after clear
    p9 = 0; #2; p9 = 1; #2;
    p15 = 1; p1 = 1;
    for (int i = 1; i <= 8; i++) begin
      pulse();
      check($sformatf("fill_e%0d", i), p13, (i == 8) ? 1'b1 : 1'b0);
    end

    // inhibit: load 80, raise p6 while p7 high
    p15 = 0; setd(8'h80); p1 = 0;
    p7 = 1; #2;
    p6 = 1; #3;
    p7 = 0; #5;
    check("inh_load", p13, 1'b1);
    p15 = 1;
    for (int i = 0; i < 5; i++) begin
      pulse();
      check("inh_hold", p13, 1'b1);
    end
    p7 = 1; #2;
    p6 = 0; #3;
    p7 = 0; #5;
    check("inh_drop", p13, 1'b1);
    pulse();
    check("inh_shift", p13, 1'b0);

    // clear held across a load edge
    p9 = 0; p15 = 0; setd(8'hFF);
    #2;
    pulse();
    check("clr_vs_clk", p13, 1'b0);
    p9 = 1;
    #2;
    pulse();
    check("load_after_clr", p13, 1'b1);

    // counter-driven reload every 8th dot
    pat = 16'b10000001_00111100;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 8; k++) begin
        p15 = (k == 0) ? 1'b0 : 1'b1;
        setd((c % 2 == 0) ? 8'h81 : 8'h3C);
        p1 = 1'b1;
        pulse();
        check($sformatf("stream_c%0d_b%0d", c, k), p13,
              pat[15 - ((c % 2) * 8 + k)]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
